knn_vote: RTL and testbench

KNN_VOTE -- requirements
Module: knn_vote

---
 rtl/knn_vote.sv | 143 ++++++++++++++
 tb/tb_knn_vote.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// knn_vote: majority vote over the K nearest-neighbour labels.
//
// Accepts one set of N_Neighbour labels (neighbour 0 in the low slice). It
// counts votes per class one neighbour per cycle, then scans the classes one
// per cycle for the highest count. On a tie the lowest class index wins. The
// result is held until the consumer takes it.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clear           synchronous abort: back to IDLE, result dropped
//   in_valid/ready  neighbour-set handshake (ready only in IDLE)
//   in_info         N_Neighbour packed labels, slice j = neighbour j
//   out_valid/ready result handshake
//   out_label       winning class
//   out_votes       vote count of the winning class
//   out_err         some label in the set was >= N_CLASSES
module knn_vote #(
  parameter int LABEL       = 4,
  parameter int N_Neighbour = 4,
  parameter int N_CLASSES   = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               in_valid,
  input  logic [N_Neighbour*LABEL-1:0]       in_info,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LABEL-1:0]                   out_label,
  output logic [$clog2(N_Neighbour+1)-1:0]   out_votes,
  output logic                               out_err
);

  localparam int CW  = $clog2(N_Neighbour+1);
  localparam int NIW = (N_Neighbour > 1) ? $clog2(N_Neighbour) : 1;
  // class index runs one past the last class: that step loads the outputs
  localparam int CIW = $clog2(N_CLASSES+1);
  localparam logic [LABEL:0] NCL = (LABEL+1)'(N_CLASSES);

  typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;

  state_t                          state;
  logic [N_Neighbour*LABEL-1:0]    info;
  logic [N_CLASSES-1:0][CW-1:0]    cnt;
  logic [CW-1:0]                   best_cnt;
  logic [LABEL-1:0]                best_lab;
  logic                            err;
  logic [NIW-1:0]                  nidx;
  logic [CIW-1:0]                  cidx;

  logic [LABEL-1:0]                cur_lab;
  logic                            cur_ok;

  assign in_ready = (state == IDLE);

  // label of the neighbour currently being counted
  always_comb begin
    cur_lab = '0;
    for (int j = 0; j < N_Neighbour; j++)
      if (nidx == NIW'(j)) cur_lab = info[j*LABEL +: LABEL];
  end

  assign cur_ok = ({1'b0, cur_lab} < NCL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      info      <= '0;
      cnt       <= '0;
      best_cnt  <= '0;
      best_lab  <= '0;
      err       <= 1'b0;
      nidx      <= '0;
      cidx      <= '0;
      out_valid <= 1'b0;
      out_label <= '0;
      out_votes <= '0;
      out_err   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      best_cnt  <= '0;
      best_lab  <= '0;
      err       <= 1'b0;
      nidx      <= '0;
      cidx      <= '0;
      out_valid <= 1'b0;
      out_label <= '0;
      out_votes <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          info     <= in_info;
          cnt      <= '0;
          best_cnt <= '0;
          best_lab <= '0;
          err      <= 1'b0;
          nidx     <= '0;
          state    <= COUNT;
        end
        COUNT: begin
          if (cur_ok) begin
            for (int c = 0; c < N_CLASSES; c++)
              if (cur_lab == LABEL'(c)) cnt[c] <= cnt[c] + 1'b1;
          end else begin
            err <= 1'b1;
          end
          if (nidx == NIW'(N_Neighbour-1)) begin
            cidx  <= '0;
            state <= SCAN;
          end else begin
            nidx <= nidx + 1'b1;
          end
        end
        SCAN: begin
          if (cidx == CIW'(N_CLASSES)) begin
            out_label <= best_lab;
            out_votes <= best_cnt;
            out_err   <= err;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            // strict > keeps the earlier (lower) class on a tie
            for (int c = 0; c < N_CLASSES; c++)
              if (cidx == CIW'(c) && cnt[c] > best_cnt) begin
                best_cnt <= cnt[c];
                best_lab <= LABEL'(c);
              end
            cidx <= cidx + 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// Directed bench for knn_vote (K=4, LABEL=4, N_CLASSES=10).
module tb_knn_vote;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_info;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_label;
  logic [2:0]  out_votes;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  knn_vote #(.LABEL(4), .N_Neighbour(4), .N_CLASSES(10)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_info(in_info), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_label(out_label), .out_votes(out_votes), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input int n0, input int n1, input int n2, input int n3);
    pack = {4'(n3), 4'(n2), 4'(n1), 4'(n0)};
  endfunction

  // drive a set at the falling edge; returns just after the accepting edge
  task automatic submit(input logic [15:0] info);
    @(negedge clk);
    in_valid = 1'b1;
    in_info  = info;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // edges from the accept edge until out_valid is seen high (bounded)
  task automatic wait_out(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic check_res(input string tag, input int lab, input int votes, input int err);
    check({tag, ".label"}, out_label, lab);
    check({tag, ".votes"}, out_votes, votes);
    check({tag, ".err"},   out_err,   err);
  endtask

  // full transaction with out_ready held high
  task automatic run(input string tag, input logic [15:0] info,
                     input int lab, input int votes, input int err);
    int n;
    submit(info);
    wait_out(n);
    check({tag, ".latency"}, n, 15);
    check_res(tag, lab, votes, err);
    @(posedge clk);
    @(negedge clk);
    check({tag, ".drop_valid"}, out_valid, 0);
    check({tag, ".ready_back"}, in_ready, 1);
  endtask

  initial begin
    int n;
    int stable_bad;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_info = '0; out_ready = 1'b1;
    #1;
    check("rst.in_ready",  in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check_res("rst", 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // plain majority, ties, invalid labels
    run("basic",   pack(3, 3, 7, 1),     3, 2, 0);
    run("tie_a",   pack(2, 5, 5, 2),     2, 2, 0);
    run("tie_b",   pack(9, 9, 4, 4),     4, 2, 0);
    run("inv",     pack(12, 6, 15, 6),   6, 2, 1);
    run("all_inv", pack(15, 15, 15, 15), 0, 0, 1);
    run("lab10",   pack(10, 9, 0, 0),    0, 2, 1);

    // backpressure: result held, second set waits for the consume edge
    out_ready = 1'b0;
    submit(pack(0, 0, 1, 2));
    check("bp.in_ready_busy", in_ready, 0);
    wait_out(n);
    check("bp.latency", n, 15);
    check_res("bp", 0, 2, 0);
    in_valid = 1'b1;
    in_info  = pack(6, 6, 6, 1);
    stable_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_label !== 4'd0 ||
          out_votes !== 3'd2 || out_err !== 1'b0) stable_bad++;
    end
    check("bp.held_cycles_bad", stable_bad, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp.consumed_valid", out_valid, 0);
    check("bp.consumed_ready", in_ready, 1);
    @(posedge clk);       // accepting edge for the second set
    #1 in_valid = 1'b0;
    check("bp.second_accept", in_ready, 0);
    wait_out(n);
    check("bp2.latency", n, 15);
    check_res("bp2", 6, 3, 0);
    @(posedge clk);
    @(negedge clk);
    check("bp2.drop_valid", out_valid, 0);

    // clear during SCAN wipes the class-1 votes
    submit(pack(1, 1, 1, 1));
    repeat (6) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr.in_ready",  in_ready, 1);
    check("clr.out_valid", out_valid, 0);
    run("after_clr", pack(8, 0, 8, 8), 8, 3, 0);

    // async reset mid-COUNT
    submit(pack(5, 5, 5, 5));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst.in_ready",  in_ready, 1);
    check("arst.out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    run("after_rst", pack(4, 4, 4, 4), 4, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
